// File: rtl/dff_ram_arbiter_pkg.sv
// dff_ram_arbiter_pkg: shared FSM state type, RAM op encodings and default geometry for dff_ram_arbiter.
// Optional feature macro used by this slice: RAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package dff_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic RAM_OP_WRITE = 1'b0;
    localparam logic RAM_OP_READ  = 1'b1;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 72;

endpackage

// File: rtl/dff_ram_arbiter_if.sv
// dff_ram_arbiter_if: requester-side command/response bus of dff_ram_arbiter.
// Signals: req_valid/req_ready/req_wr/req_addr/req_wdata carry commands (flattened per requester),
//          rsp_valid/rsp_ready/rsp_rdata carry read responses (rsp_rdata shared by all requesters).
// Modports: master = requesters, slave = arbiter.
interface dff_ram_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 72
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dff_ram_arbiter_rr_arbiter.sv
// rr_arbiter: picks one requester from a request vector.
// Ports: req (request vector), last_grant (previous winner index) -> grant (one-hot), idx (winner), any.
// Default: round-robin, search starts at last_grant+1. With RAM_ARB_FIXED_PRIO_EN defined the lowest
// index wins and last_grant is ignored.
module rr_arbiter
    import dff_ram_arb_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int c;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            c = i;
`else
            c = (int'(last_grant) + 1 + i) % NUM_REQ;
`endif
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/dff_ram_arbiter.sv
// dff_ram_arbiter: shares one DFF RAM between NUM_REQ requesters and returns read data to the owner.
// Ports: clk, rst_n (sync, active-low), bus (dff_ram_arbiter_if.slave: commands and responses),
//        ram_en_n/ram_wr/ram_address/ram_wdata (registered RAM controls), ram_rdata (RAM read data).
// Config: RAM_ARB_FIXED_PRIO_EN selects fixed-priority arbitration inside rr_arbiter.
module dff_ram_arbiter
    import dff_ram_arb_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  ADDR_W  = DEF_ADDR_W,
    parameter int  DATA_W  = DEF_DATA_W,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    dff_ram_arbiter_if.slave  bus,
    output logic              ram_en_n,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, last_grant, win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic               win_any, accept, rsp_done;
    logic [DATA_W-1:0]  rsp_rdata_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (win_grant),
        .idx        (win_idx),
        .any        (win_any)
    );

    // Ready is offered only while idle and out of reset, so a requester held valid during reset
    // never sees a handshake.
    assign bus.req_ready = (state == IDLE && rst_n) ? win_grant : '0;
    assign accept        = win_any && state == IDLE && rst_n;
    assign bus.rsp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign rsp_done      = state == RESP && bus.rsp_ready[owner];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = accept ? ISSUE : IDLE;
            ISSUE:   state_nxt = (ram_wr == RAM_OP_READ) ? WAIT : IDLE;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = rsp_done ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // The RAM control registers double as the latched command: they load on accept and then
    // hold, while the enable pulses low for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_en_n    <= 1'b1;
            ram_wr      <= RAM_OP_READ;
            ram_address <= '0;
            ram_wdata   <= '0;
            rsp_rdata_q <= '0;
            owner       <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
        end else begin
            ram_en_n <= !accept;
            if (accept) begin
                ram_wr      <= bus.req_wr[win_idx];
                ram_address <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                ram_wdata   <= bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                owner       <= win_idx;
                last_grant  <= win_idx;
            end
            if (state == WAIT) rsp_rdata_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_dff_ram_arbiter.sv
// tb_dff_ram_arbiter: randomized self-checking bench for dff_ram_arbiter with a behavioural RAM.
module tb_dff_ram_arbiter;
    import dff_ram_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 2;
    localparam int DW = 72;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_en_n, ram_wr;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dff_ram_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dff_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ram_en_n    (ram_en_n),
        .ram_wr      (ram_wr),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    logic [DW-1:0] ram_mem [4];

    always @(posedge clk)
        if (!ram_en_n) begin
            if (ram_wr == RAM_OP_WRITE) ram_mem[ram_address] <= ram_wdata;
            else                        ram_rdata <= ram_mem[ram_address];
        end

    int            vecs = 0;
    int            errs = 0;
    int            mdl_last;
    logic [N-1:0]  pend;
    logic [N-1:0]  r_wr;
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_data [N];
    logic [DW-1:0] mdl_mem [4];
    logic [DW-1:0] last_rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        bus.req_valid = pend;
        bus.req_wr    = r_wr;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = r_addr[i];
            bus.req_wdata[i*DW +: DW] = r_data[i];
        end
        #1;
    endtask

    // Expected winner: the pending requester closest after the previous winner in circular order
    // (or simply the lowest pending index with fixed priority).
    function automatic int pick(input logic [N-1:0] p);
        int best = -1;
        int bd   = N;
        int d;
        for (int i = 0; i < N; i++)
            if (p[i]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                d = i;
`else
                d = (i - mdl_last - 1 + 2 * N) % N;
`endif
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        return best;
    endfunction

    task automatic do_reset();
        pend = '0;
        drive();
        rst_n = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
        mdl_last = N - 1;
    endtask

    // Serves one pending command end to end and checks every cycle of it.
    task automatic round(input int dly, output int who);
        logic [N-1:0]  eg, oh;
        logic [DW-1:0] exp_d;
        logic [AW-1:0] a;
        int            best, n;
        best = pick(pend);
        eg   = '0;
        if (best >= 0) eg[best] = 1'b1;
        who = -1;
        n   = 0;
        drive();
        while (bus.req_ready === '0 && n < 8) begin
            step();
            drive();
            n++;
        end
        vecs++;
        if (bus.req_ready !== eg) begin
            errs++;
            $display("FAIL grant: req_ready=%b expected %b", bus.req_ready, eg);
        end
        for (int i = 0; i < N; i++) if (bus.req_ready[i] === 1'b1 && who < 0) who = i;
        if (who < 0) return;
        mdl_last  = who;
        a         = r_addr[who];
        pend[who] = 1'b0;
        step();
        drive();
        vecs++;
        if ({ram_en_n, ram_wr, ram_address, ram_wdata, bus.req_ready} !==
            {1'b0, r_wr[who], a, r_data[who], N'(0)}) begin
            errs++;
            $display("FAIL issue: en_n=%b wr=%b addr=%h wdata=%h ready=%b expected en_n=0 wr=%b addr=%h wdata=%h ready=0",
                     ram_en_n, ram_wr, ram_address, ram_wdata, bus.req_ready, r_wr[who], a, r_data[who]);
        end
        if (r_wr[who] == RAM_OP_WRITE) begin
            mdl_mem[a] = r_data[who];
            step();
            drive();
            vecs++;
            if (ram_en_n !== 1'b1) begin
                errs++;
                $display("FAIL write_end: ram_en_n=%b expected 1", ram_en_n);
            end
            return;
        end
        exp_d   = mdl_mem[a];
        oh      = '0;
        oh[who] = 1'b1;
        step();
        drive();
        vecs++;
        if ({ram_en_n, bus.rsp_valid, bus.req_ready} !== {1'b1, N'(0), N'(0)}) begin
            errs++;
            $display("FAIL wait: en_n=%b rsp_valid=%b ready=%b expected 1/0/0",
                     ram_en_n, bus.rsp_valid, bus.req_ready);
        end
        step();
        drive();
        vecs++;
        if (bus.rsp_valid !== oh || bus.rsp_rdata !== exp_d) begin
            errs++;
            $display("FAIL resp: rsp_valid=%b rdata=%h expected %b %h", bus.rsp_valid, bus.rsp_rdata, oh, exp_d);
        end
        last_rd = bus.rsp_rdata;
        for (int d = 0; d < dly; d++) begin
            bus.rsp_ready = ~oh;
            step();
            drive();
            vecs++;
            if (bus.rsp_valid !== oh || bus.rsp_rdata !== exp_d || bus.req_ready !== '0) begin
                errs++;
                $display("FAIL hold: rsp_valid=%b rdata=%h ready=%b expected %b %h 0",
                         bus.rsp_valid, bus.rsp_rdata, bus.req_ready, oh, exp_d);
            end
        end
        bus.rsp_ready = oh;
        step();
        bus.rsp_ready = '0;
        drive();
        vecs++;
        if (bus.rsp_valid !== '0) begin
            errs++;
            $display("FAIL release: rsp_valid=%b expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_reset();
        pend = '1;
        drive();
        for (int k = 0; k < 2; k++) begin
            step();
            vecs++;
            if ({bus.req_ready, ram_en_n, bus.rsp_valid} !== {N'(0), 1'b1, N'(0)}) begin
                errs++;
                $display("FAIL reset: ready=%b en_n=%b rsp_valid=%b expected 0/1/0",
                         bus.req_ready, ram_en_n, bus.rsp_valid);
            end
        end
        pend = '0;
        drive();
        rst_n    = 1'b1;
        mdl_last = N - 1;
    endtask

    task automatic test_write_read();
        int w;
        do_reset();
        r_wr[0]   = RAM_OP_WRITE;
        r_addr[0] = 2'd2;
        r_data[0] = {9{8'hA5}};
        pend      = 2'b01;
        round(0, w);
        r_wr[0] = RAM_OP_READ;
        pend    = 2'b01;
        round(0, w);
        vecs++;
        if (w !== 0 || last_rd !== {9{8'hA5}}) begin
            errs++;
            $display("FAIL write_read: owner=%0d rdata=%h expected 0 %h", w, last_rd, {9{8'hA5}});
        end
    endtask

    task automatic test_same_cycle();
        int w1, w2;
        r_wr[1]   = RAM_OP_WRITE;
        r_addr[1] = 2'd3;
        r_data[1] = 72'h1;
        r_wr[0]   = RAM_OP_READ;
        r_addr[0] = 2'd3;
        pend      = 2'b11;
        round(0, w1);
        round(0, w2);
        vecs++;
`ifdef RAM_ARB_FIXED_PRIO_EN
        if (w1 !== 0 || w2 !== 1) begin
            errs++;
            $display("FAIL same_cycle: order %0d,%0d expected 0,1", w1, w2);
        end
`else
        if (w1 !== 1 || w2 !== 0 || last_rd !== 72'h1) begin
            errs++;
            $display("FAIL same_cycle: order %0d,%0d rdata=%h expected 1,0 %h", w1, w2, last_rd, 72'h1);
        end
`endif
    endtask

    task automatic test_alternate();
        int w;
        do_reset();
        r_wr      = 2'b11;
        r_addr[0] = 2'd1;
        r_addr[1] = 2'd2;
        pend      = 2'b11;
        for (int k = 0; k < 4; k++) begin
            round(0, w);
            vecs++;
`ifdef RAM_ARB_FIXED_PRIO_EN
            if (w !== 0) begin
`else
            if (w !== k % 2) begin
`endif
                errs++;
                $display("FAIL alternate: grant %0d at round %0d", w, k);
            end
            if (w >= 0) pend[w] = 1'b1;
        end
        while (pend != '0) begin
            round(0, w);
            if (w < 0) break;
        end
    endtask

    task automatic test_backpressure();
        int w;
        r_wr      = 2'b11;
        r_addr[0] = 2'd2;
        r_addr[1] = 2'd3;
        pend      = 2'b11;
        round(5, w);
        round(0, w);
    endtask

    task automatic test_reset_in_wait();
        r_wr[0]   = RAM_OP_READ;
        r_addr[0] = 2'd2;
        pend      = 2'b01;
        drive();
        vecs++;
        if (bus.req_ready !== pick(pend) + 1) begin
            errs++;
            $display("FAIL rw_accept: ready=%b expected 01", bus.req_ready);
        end
        step();
        pend = '0;
        drive();
        step();
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        mdl_last = N - 1;
        vecs++;
        if ({bus.rsp_valid, ram_en_n, ram_wr, ram_address, ram_wdata, bus.rsp_rdata} !==
            {N'(0), 1'b1, 1'b1, AW'(0), DW'(0), DW'(0)}) begin
            errs++;
            $display("FAIL reset_wait: rsp_valid=%b en_n=%b wr=%b addr=%h wdata=%h rdata=%h expected 0 1 1 0 0 0",
                     bus.rsp_valid, ram_en_n, ram_wr, ram_address, ram_wdata, bus.rsp_rdata);
        end
        bus.rsp_ready = '1;
        for (int k = 0; k < 6; k++) begin
            step();
            vecs++;
            if (bus.rsp_valid !== '0) begin
                errs++;
                $display("FAIL no_resp: rsp_valid=%b expected 0 at cycle %0d", bus.rsp_valid, k);
            end
        end
        bus.rsp_ready = '0;
    endtask

    task automatic test_random();
        int w, j;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    r_wr[i]   = 1'($urandom);
                    r_addr[i] = AW'($urandom);
                    r_data[i] = DW'({$urandom, $urandom, $urandom});
                    pend[i]   = 1'b1;
                end
            if (pend == '0) begin
                j         = int'($urandom_range(0, N - 1));
                r_wr[j]   = 1'($urandom);
                r_addr[j] = AW'($urandom);
                r_data[j] = DW'({$urandom, $urandom, $urandom});
                pend[j]   = 1'b1;
            end
            round(int'($urandom_range(0, 2)), w);
            if (w < 0) pend = '0;
        end
        while (pend != '0) begin
            round(0, w);
            if (w < 0) pend = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ram_mem[i] = '0;
            mdl_mem[i] = '0;
        end
        ram_rdata     = '0;
        r_wr          = '0;
        r_addr[0]     = '0;
        r_addr[1]     = '0;
        r_data[0]     = '0;
        r_data[1]     = '0;
        bus.rsp_ready = '0;
        mdl_last      = N - 1;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_alternate();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
